// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised integer register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   ZERO_REG             : architectural zero register index
//   port_lsb()           : LSB offset of a port's field in a packed port bus
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
// Issue reserves a destination and writeback releases it. When both hit the
// same register in one cycle, the reservation wins because it belongs to a
// younger instruction. Register 0 is never busy.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rsv_en, rsv_addr  reserve request (set busy)
//   wr_en, wr_addr    writeback (clear busy)
//   busy_vec          scoreboard state, bit 0 tied to 0
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:1] busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (rsv_en && rsv_addr == AW'(i))
                    busy_q[i] <= 1'b1;
                else if (wr_en && wr_addr == AW'(i))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    assign busy_vec = {busy_q, 1'b0};

endmodule

// File: rtl/regfile_sb_param.sv
// Parametrised integer register file with busy scoreboard.
// Registered (1-cycle) reads on NREAD independent ports; one writeback port;
// one reservation port. Register 0 reads as zero and is never busy.
// Optional macro REGFILE_BYPASS_EN: when defined, a read of the address being
// written in the same cycle returns the write data and the post-edge busy bit
// (write-first); when undefined, reads return the pre-edge contents.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rd_en[p]          read request for port p
//   rd_addr           packed read addresses, port p at [p*AW +: AW]
//   rd_data           packed registered read data, port p at [p*XLEN +: XLEN]
//   rd_busy[p]        registered busy flag of the register read on port p
//   rsv_en, rsv_addr  reserve destination at issue
//   wr_en, wr_addr, wr_data  writeback
//   busy_vec          current scoreboard
module regfile_sb_param import regfile_pkg::*; #(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD-1:0]      rd_en,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0] mem [NREGS];
    logic [AW-1:0]   ra [NREAD];
    logic [XLEN-1:0] nxt_data [NREAD];
    logic [NREAD-1:0] nxt_busy;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (wr_en && wr_addr != AW'(ZERO_REG)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            ra[p]       = rd_addr[port_lsb(p, AW) +: AW];
            nxt_data[p] = '0;
            nxt_busy[p] = 1'b0;
            if (ra[p] != AW'(ZERO_REG)) begin
                nxt_data[p] = mem[ra[p]];
                nxt_busy[p] = busy_vec[ra[p]];
`ifdef REGFILE_BYPASS_EN
                // Write-first: forward the data and the busy bit as it will
                // stand after this edge (a same-cycle reserve still wins).
                if (wr_en && wr_addr == ra[p]) begin
                    nxt_data[p] = wr_data;
                    nxt_busy[p] = rsv_en && (rsv_addr == ra[p]);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int p = 0; p < NREAD; p++) begin
                if (rd_en[p]) begin
                    rd_data[port_lsb(p, XLEN) +: XLEN] <= nxt_data[p];
                    rd_busy[p]                         <= nxt_busy[p];
                end
            end
        end
    end

endmodule

// File: doc/regfile_sb_param.md
Name: regfile_sb_param

Overview:
Parametrised integer register file for the pipelined RV32I core, successor to the fixed 32x32 two-read/one-write bank.
- Configurable data width, register count and number of read ports.
- Registered (1-cycle) reads.
- Per-register busy scoreboard: issue reserves a destination, writeback releases it.
- Sits between decode/issue (reads, reservations) and writeback (writes).
- Register 0 is hardwired to zero and is never busy.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers; power of two, at least 2
NREAD, 2, number of independent read ports, 1..4
AW, $clog2(NREGS), address width; localparam, not overridable

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
rd_en  input  NREAD  per-port read request
rd_addr  input  NREAD*AW  packed read addresses, port p at [p*AW +: AW]
rd_data  output  NREAD*XLEN  packed registered read data
rd_busy  output  NREAD  registered busy flag of the register read on that port
rsv_en  input  1  reserve destination (issue)
rsv_addr  input  AW  register to mark busy
wr_en  input  1  writeback enable
wr_addr  input  AW  writeback register
wr_data  input  XLEN  writeback data
busy_vec  output  NREGS  current scoreboard, bit 0 always 0

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- Reset clears all registers, busy_vec, rd_data and rd_busy to 0. These are the values on the first edge after rst falls.
- Reset asserted mid-operation clears everything at once. Pending reservations are lost.
- Write: on an edge with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - wr_addr=0 is ignored entirely.
- Reserve: on an edge with rsv_en=1 and rsv_addr!=0, busy[rsv_addr] <= 1.
  - rsv_addr=0 is ignored.
- Reserve and write to the same nonzero address in the same cycle:
  - data is written;
  - busy ends at 1, because the reservation belongs to a younger instruction and wins.
- Reserving a register that is already busy keeps it busy. There is no counting: one write clears it.
- Read port p: on an edge with rd_en[p]=1, rd_data[p] and rd_busy[p] are updated. Latency is exactly 1 cycle.
  - With rd_en[p]=0, both outputs hold their previous value.
- rd_addr=0 returns data 0 and busy 0 on every configuration.
- Same-cycle write and read of the same address: behaviour is set by the optional feature below.
- Ports are independent. Any ports may read the same address in the same cycle with identical results.
- busy_vec is a direct view of the scoreboard flops; bit 0 is tied to 0.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined (write-first): a read port sampling the same nonzero address as a same-cycle write returns wr_data.
  - Its rd_busy reflects the post-edge state: 0, unless the same-cycle reserve hits that address, then 1.
- Undefined (read-first): the read returns the old register content.
  - rd_busy reflects the pre-edge busy bit.
  - The pipeline must then insert one stall for write-to-read hazards.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN and NREGS defaults;
  - the ZERO_REG constant (0);
  - the packed-port slice helper function.
- Natural sub-module regfile_scoreboard: the NREGS busy flops with reserve/release priority logic and bit 0 forced to 0.
  - Ports: clk, rst, rsv_en, rsv_addr, wr_en, wr_addr, busy_vec.
- The data array and read ports stay in the top.

Test Plan:
- Reset then read x5 on port 0 -> one cycle later rd_data[0]=0, rd_busy[0]=0, busy_vec=0.
- Write x7=0xDEADBEEF, next cycle read x7 on both ports -> both return 0xDEADBEEF after 1 cycle. Write x0=0x1234, read x0 -> 0.
- Reserve x3, then check busy_vec[3]=1. Write x3=0x55 -> busy_vec[3]=0 next cycle. Reserve x0 -> busy_vec stays 0.
- Same cycle reserve x4 and write x4=0xA5A5A5A5 -> mem[4]=0xA5A5A5A5, busy_vec[4]=1.
- Same cycle write x9=0x11 over old 0x22 and read x9:
  - with REGFILE_BYPASS_EN -> rd_data=0x11;
  - without -> rd_data=0x22, and the next read gives 0x11.
- Mid-stream: write x1..x31, reserve x10, assert rst for half a cycle -> all reads 0, busy_vec=0. Hold rd_en low for 3 cycles -> rd_data unchanged.
